uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the number of data bits per frame.
REQ-002 SHALL have parameter CLK_FREQ, default 50000000, the clk frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 19200, the line bit rate.
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-007 SHALL have port rx_data_out  output  DATA_WIDTH  last correctly framed word, registered.
REQ-008 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data_out is updated.
REQ-009 SHALL have port rx_active  output  1  high while in START, DATA or STOP.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.

Function
REQ-011 SHALL define CLK_DIVIDE = CLK_FREQ / BAUD_RATE (integer division), in clk cycles per bit.
REQ-012 SHALL pass rx through a two-flop synchronizer (rx_sync); all decisions use only rx_sync.
REQ-013 SHALL use states IDLE, START, DATA, STOP, DONE, RECOVER.
REQ-014 IDLE: clear bit counter and index; rx_sync==0 -> START.
REQ-015 START: after CLK_DIVIDE/2 cycles in the state, sample rx_sync; 0 -> DATA (counter cleared); 1 -> IDLE (false start, no output pulse).
REQ-016 DATA: sample rx_sync once per CLK_DIVIDE cycles into shift register bit [index], LSB first; after bit DATA_WIDTH-1 -> STOP.
REQ-017 STOP: after CLK_DIVIDE cycles, sample rx_sync; 1 -> DONE with ok flag; 0 -> DONE with error flag.
REQ-018 DONE (one cycle): ok -> load rx_data_out from the shift register, rx_valid=1, then IDLE; error -> frame_err=1, rx_data_out unchanged, then RECOVER.
REQ-019 RECOVER: stay until rx_sync==1, then IDLE; a held-low line (break) SHALL NOT produce further frames.
REQ-020 The bit counter SHALL count 0..CLK_DIVIDE-1 and wrap to 0 on each sample; its width is $clog2(CLK_DIVIDE)+1.
REQ-021 rx_valid and frame_err SHALL never be high in the same cycle.
REQ-022 rx_data_out SHALL hold its value until the next rx_valid.
REQ-023 A new start bit SHALL be accepted in the first IDLE cycle after DONE (back-to-back frames with one stop bit).
REQ-024 rx activity in DONE SHALL be ignored.

Reset
REQ-025 While rst is high: state=IDLE, synchronizer flops=1, counter=0, index=0, shift register=0, rx_data_out=0, rx_valid=0, frame_err=0, rx_active=0.
REQ-026 rst asserted mid-frame SHALL abandon the frame with no rx_valid or frame_err pulse; reception restarts on the next falling edge after rst deasserts.

Structure
REQ-027 The state enum and a CLK_DIVIDE helper function SHALL live in a shared package uart_pkg, to be reused by the transmitter.
REQ-028 The two-flop synchronizer SHALL be a sub-module named sync_2ff (reset value parameterised, here 1); all other logic is flat in uart_rx.

Verification (CLK_FREQ=16, BAUD_RATE=1, so CLK_DIVIDE=16)
REQ-029 Frame 0xA5 (start 0, bits LSB first, stop 1, 16 cycles per bit) -> exactly one rx_valid with rx_data_out=0xA5, frame_err stays 0.
REQ-030 rx low for 4 cycles, then high -> return to IDLE, no rx_valid, no frame_err, rx_data_out unchanged.
REQ-031 Frame 0x3C with stop bit 0, line held low 40 more cycles, then high -> one frame_err pulse, no rx_valid, rx_data_out keeps its prior value; a following frame 0x81 -> rx_valid with 0x81.
REQ-032 Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses with 0x00 then 0xFF.
REQ-033 rst pulsed during bit 3 of a frame -> all outputs 0 next cycle, no pulse for that frame; the next frame 0x5A is received correctly.
REQ-034 Frame 0x55 at ±3% bit period -> rx_data_out=0x55 with rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and the
// baud divider helper used to size bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE,
        RECOVER
    } uart_state_t;

    function automatic int clk_divide(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a
// parameterised reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing, mid-bit sampling, frame error
// reporting and break recovery.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 19200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data_out,
    output logic                  rx_valid,
    output logic                  rx_active,
    output logic                  frame_err
);

    localparam int CLK_DIVIDE = clk_divide(CLK_FREQ, BAUD_RATE);
    localparam int CW = $clog2(CLK_DIVIDE) + 1;
    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIVIDE - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIVIDE / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    uart_state_t           r_state;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_ok;
    logic                  r_valid;
    logic                  r_err;
    logic                  r_active;
    logic                  w_rx_sync;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .i_d(rx),
        .o_q(w_rx_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_ok     <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (!w_rx_sync) begin
                        r_state  <= START;
                        r_active <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (w_rx_sync) begin
                            r_state  <= IDLE;
                            r_active <= 1'b0;
                        end else begin
                            r_state <= DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        // LSB arrives first, so shifting right lands it in bit 0
                        r_shift <= {w_rx_sync, r_shift[DATA_WIDTH-1:1]};
                        if (r_idx == IDX_LAST) begin
                            r_state <= STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt    <= '0;
                        r_ok     <= w_rx_sync;
                        r_state  <= DONE;
                        r_active <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (r_ok) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= RECOVER;
                    end
                end
                RECOVER: begin
                    // A held-low break must release before we re-arm
                    if (w_rx_sync) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data_out = r_data;
    assign rx_valid    = r_valid;
    assign rx_active   = r_active;
    assign frame_err   = r_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data_out;
    logic       rx_valid;
    logic       rx_active;
    logic       frame_err;

    int checks;
    int errors;
    int valid_cnt;
    int err_cnt;
    int both_cnt;
    logic [7:0] hist[$];

    localparam int BIT_NS = 160;

    uart_rx #(
        .DATA_WIDTH(8),
        .CLK_FREQ(16),
        .BAUD_RATE(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_data_out(rx_data_out),
        .rx_valid(rx_valid),
        .rx_active(rx_active),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt++;
            hist.push_back(rx_data_out);
        end
        if (frame_err) err_cnt++;
        if (rx_valid && frame_err) both_cnt++;
    end

    task automatic send_frame(input logic [7:0] d, input logic stopb,
                              input int bit_ns, output logic act);
        rx = 1'b0;
        #(bit_ns);
        act = rx_active;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bit_ns);
        end
        rx = stopb;
        #(bit_ns);
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rx  = 1'b1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %h want 00", rx_data_out);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", rx_valid);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ferr got %b want 0", frame_err);
        end
        checks++;
        if (rx_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_active got %b want 0", rx_active);
        end
        rst = 1'b0;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_frame();
        int v0, e0;
        logic act;
        align();
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'hA5, 1'b1, BIT_NS, act);
        rx = 1'b1;
        #300;
        checks++;
        if (act !== 1'b1) begin
            errors++;
            $display("FAIL frame_active got %b want 1", act);
        end
        checks++;
        if (valid_cnt !== v0 + 1) begin
            errors++;
            $display("FAIL frame_valid_cnt got %0d want %0d", valid_cnt - v0, 1);
        end
        checks++;
        if (rx_data_out !== 8'hA5) begin
            errors++;
            $display("FAIL frame_data got %h want a5", rx_data_out);
        end
        checks++;
        if (err_cnt !== e0) begin
            errors++;
            $display("FAIL frame_ferr got %0d want 0", err_cnt - e0);
        end
    endtask

    task automatic test_false_start();
        int v0, e0;
        align();
        v0 = valid_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        #40;
        rx = 1'b1;
        #300;
        checks++;
        if (valid_cnt !== v0) begin
            errors++;
            $display("FAIL false_valid got %0d want 0", valid_cnt - v0);
        end
        checks++;
        if (err_cnt !== e0) begin
            errors++;
            $display("FAIL false_ferr got %0d want 0", err_cnt - e0);
        end
        checks++;
        if (rx_data_out !== 8'hA5) begin
            errors++;
            $display("FAIL false_data got %h want a5", rx_data_out);
        end
        checks++;
        if (rx_active !== 1'b0) begin
            errors++;
            $display("FAIL false_active got %b want 0", rx_active);
        end
    endtask

    task automatic test_frame_err();
        int v0, e0;
        logic act;
        align();
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0, BIT_NS, act);
        #400;
        rx = 1'b1;
        #300;
        checks++;
        if (err_cnt !== e0 + 1) begin
            errors++;
            $display("FAIL ferr_cnt got %0d want 1", err_cnt - e0);
        end
        checks++;
        if (valid_cnt !== v0) begin
            errors++;
            $display("FAIL ferr_valid got %0d want 0", valid_cnt - v0);
        end
        checks++;
        if (rx_data_out !== 8'hA5) begin
            errors++;
            $display("FAIL ferr_data got %h want a5", rx_data_out);
        end
        send_frame(8'h81, 1'b1, BIT_NS, act);
        rx = 1'b1;
        #300;
        checks++;
        if (valid_cnt !== v0 + 1) begin
            errors++;
            $display("FAIL after_ferr_valid got %0d want 1", valid_cnt - v0);
        end
        checks++;
        if (rx_data_out !== 8'h81) begin
            errors++;
            $display("FAIL after_ferr_data got %h want 81", rx_data_out);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        logic act;
        align();
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1, BIT_NS, act);
        send_frame(8'hFF, 1'b1, BIT_NS, act);
        rx = 1'b1;
        #300;
        checks++;
        if (valid_cnt !== v0 + 2) begin
            errors++;
            $display("FAIL b2b_cnt got %0d want 2", valid_cnt - v0);
        end
        checks++;
        if (hist.size() < 2 || hist[hist.size()-2] !== 8'h00) begin
            errors++;
            $display("FAIL b2b_first got %h want 00",
                     hist.size() >= 2 ? hist[hist.size()-2] : 8'hxx);
        end
        checks++;
        if (hist.size() < 1 || hist[hist.size()-1] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_second got %h want ff",
                     hist.size() >= 1 ? hist[hist.size()-1] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid();
        int v0, e0;
        time t0;
        logic act;
        logic [7:0] d;
        d = 8'hF8;
        align();
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            #(BIT_NS);
        end
        rx = d[3];
        t0 = $time;
        #80;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_data_out !== 8'h00 || rx_valid !== 1'b0 ||
            frame_err !== 1'b0 || rx_active !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outs got %h/%b/%b/%b want 00/0/0/0",
                     rx_data_out, rx_valid, frame_err, rx_active);
        end
        #1;
        rst = 1'b0;
        v0 = valid_cnt;
        e0 = err_cnt;
        #(t0 + BIT_NS - $time);
        for (int i = 4; i < 8; i++) begin
            rx = d[i];
            #(BIT_NS);
        end
        rx = 1'b1;
        #(BIT_NS);
        #300;
        checks++;
        if (valid_cnt !== v0) begin
            errors++;
            $display("FAIL midrst_valid got %0d want 0", valid_cnt - v0);
        end
        checks++;
        if (err_cnt !== e0) begin
            errors++;
            $display("FAIL midrst_ferr got %0d want 0", err_cnt - e0);
        end
        align();
        send_frame(8'h5A, 1'b1, BIT_NS, act);
        rx = 1'b1;
        #300;
        checks++;
        if (valid_cnt !== v0 + 1) begin
            errors++;
            $display("FAIL midrst_next_valid got %0d want 1", valid_cnt - v0);
        end
        checks++;
        if (rx_data_out !== 8'h5A) begin
            errors++;
            $display("FAIL midrst_next_data got %h want 5a", rx_data_out);
        end
    endtask

    task automatic test_baud_tol();
        int v0;
        logic act;
        int periods[2];
        periods[0] = 165;
        periods[1] = 155;
        for (int k = 0; k < 2; k++) begin
            align();
            v0 = valid_cnt;
            send_frame(8'h55, 1'b1, periods[k], act);
            rx = 1'b1;
            #300;
            checks++;
            if (valid_cnt !== v0 + 1) begin
                errors++;
                $display("FAIL tol_valid_%0d got %0d want 1", periods[k], valid_cnt - v0);
            end
            checks++;
            if (rx_data_out !== 8'h55) begin
                errors++;
                $display("FAIL tol_data_%0d got %h want 55", periods[k], rx_data_out);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        valid_cnt = 0;
        err_cnt   = 0;
        both_cnt  = 0;
        rx        = 1'b1;
        rst       = 1'b1;
        test_reset();
        test_frame();
        test_false_start();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_baud_tol();
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL valid_and_ferr got %0d want 0", both_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
